// File: rtl/mc_alu_ctrl_fsm.sv
// Multicycle control FSM for the shared-ALU datapath: sequences fetch, decode,
// execute, memory and writeback steps and drives every datapath select/enable.
module mc_alu_ctrl_fsm #(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       alusrca,
    output logic [3:0] alusrcb,
    output logic [2:0] aluop,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       mdr_write,
    output logic       ab_write,
    output logic       aluout_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       exc,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        ALUWB  = 4'd7,
        EXEC_I = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        EXC    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [3:0] SRCB_B      = 4'b0000;
    localparam logic [3:0] SRCB_FOUR   = 4'b0001;
    localparam logic [3:0] SRCB_SEXT   = 4'b0010;
    localparam logic [3:0] SRCB_SEXTSH = 4'b0011;

    localparam logic [2:0] WAIT_LAST = MEM_WAIT[2:0];

    typedef struct packed {
        logic       alusrca;
        logic [3:0] alusrcb;
        logic [2:0] aluop;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       mdr_write;
        logic       ab_write;
        logic       aluout_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       exc;
    } ctl_t;

    state_t     cur;
    state_t     decode_next;
    logic [2:0] wait_cnt;
    logic       wait_done;
    logic       funct_legal;
    logic [2:0] funct_op;
    ctl_t       ctl;

    assign wait_done = (wait_cnt == WAIT_LAST);

    always_comb begin
        funct_legal = 1'b1;
        funct_op    = ALU_ADD;
        case (funct)
            6'h20:   funct_op = ALU_ADD;
            6'h22:   funct_op = ALU_SUB;
            6'h24:   funct_op = ALU_AND;
            6'h25:   funct_op = ALU_OR;
            6'h2A:   funct_op = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        decode_next = EXC;
        case (opcode)
            OP_RTYPE:      decode_next = funct_legal ? EXEC_R : EXC;
            OP_ADDI:       decode_next = EXEC_I;
            OP_LW, OP_SW:  decode_next = MEMADR;
            OP_BEQ, OP_BNE: decode_next = BRANCH;
            OP_J:          decode_next = JUMP;
            default:       decode_next = EXC;
        endcase
    end

    // The wait counter is only meaningful in FETCH/MEMRD; every transition
    // clears it so both states always start from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= FETCH;
            wait_cnt <= 3'd0;
        end else begin
            wait_cnt <= 3'd0;
            case (cur)
                FETCH: begin
                    if (wait_done) cur <= DECODE;
                    else wait_cnt <= wait_cnt + 3'd1;
                end
                DECODE: cur <= decode_next;
                MEMADR: cur <= (opcode == OP_LW) ? MEMRD : MEMWR;
                MEMRD: begin
                    if (wait_done) cur <= MEMWB;
                    else wait_cnt <= wait_cnt + 3'd1;
                end
                MEMWB:  cur <= FETCH;
                MEMWR:  cur <= FETCH;
                EXEC_R: cur <= ALUWB;
                EXEC_I: cur <= ALUWB;
                ALUWB:  cur <= FETCH;
                BRANCH: cur <= FETCH;
                JUMP:   cur <= FETCH;
                EXC:    cur <= FETCH;
                default: cur <= FETCH;
            endcase
        end
    end

    always_comb begin
        ctl = '0;
        case (cur)
            FETCH: begin
                ctl.mem_read = 1'b1;
                ctl.alusrcb  = SRCB_FOUR;
                ctl.ir_write = wait_done;
                ctl.pc_write = wait_done;
            end
            DECODE: begin
                ctl.ab_write     = 1'b1;
                ctl.alusrcb      = SRCB_SEXTSH;
                ctl.aluout_write = 1'b1;
            end
            MEMADR: begin
                ctl.alusrca      = 1'b1;
                ctl.alusrcb      = SRCB_SEXT;
                ctl.aluout_write = 1'b1;
            end
            MEMRD: begin
                ctl.mem_read  = 1'b1;
                ctl.iord      = 1'b1;
                ctl.mdr_write = wait_done;
            end
            MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            EXEC_R: begin
                ctl.alusrca      = 1'b1;
                ctl.alusrcb      = SRCB_B;
                ctl.aluop        = funct_op;
                ctl.aluout_write = 1'b1;
            end
            EXEC_I: begin
                ctl.alusrca      = 1'b1;
                ctl.alusrcb      = SRCB_SEXT;
                ctl.aluout_write = 1'b1;
            end
            ALUWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = (opcode == OP_RTYPE);
            end
            BRANCH: begin
                ctl.alusrca  = 1'b1;
                ctl.alusrcb  = SRCB_B;
                ctl.aluop    = ALU_SUB;
                ctl.pc_src   = 2'b01;
                ctl.pc_write = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
            end
            JUMP: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = 2'b10;
            end
            EXC: ctl.exc = 1'b1;
            default: ctl = '0;
        endcase
    end

    // Reset masks every output combinationally so nothing writes in the reset cycle.
    ctl_t ctl_out;
    assign ctl_out = reset ? '0 : ctl;

    assign alusrca      = ctl_out.alusrca;
    assign alusrcb      = ctl_out.alusrcb;
    assign aluop        = ctl_out.aluop;
    assign pc_write     = ctl_out.pc_write;
    assign pc_src       = ctl_out.pc_src;
    assign ir_write     = ctl_out.ir_write;
    assign mem_read     = ctl_out.mem_read;
    assign mem_write    = ctl_out.mem_write;
    assign iord         = ctl_out.iord;
    assign mdr_write    = ctl_out.mdr_write;
    assign ab_write     = ctl_out.ab_write;
    assign aluout_write = ctl_out.aluout_write;
    assign reg_write    = ctl_out.reg_write;
    assign reg_dst      = ctl_out.reg_dst;
    assign mem_to_reg   = ctl_out.mem_to_reg;
    assign exc          = ctl_out.exc;
    assign state        = reset ? 4'd0 : cur;

endmodule
